ipif_reg_bank: RTL and testbench
================================

Name: ipif_reg_bank

Overview:
- Parametrised IPIF slave register bank; next generation of the simple WO/RW/RO register file.
- Adds honoured byte enables, write-1-to-clear (W1C) interrupt status registers with per-register masks and a registered irq output, and per-register access strobes.
- Adds a single-ack handshake FSM and error acks for unmapped indices.
- Sits behind the AXI-Lite IPIF shim in every pcore that exposes registers to software.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width (multiple of 8).
- C_S_AXI_ADDR_WIDTH, 32, bus address width.
- NUM_WO_REGS, 1, software-write / hardware-read registers (>=1).
- NUM_RW_REGS, 2, software read-write registers, also visible to hardware (>=1).
- NUM_RO_REGS, 1, hardware-written, software-read registers (>=1).
- NUM_W1C_REGS, 1, sticky status registers; each has one mask register (>=1).
- RW_RESET_VALUE, 0, packed NUM_RW_REGS*C_S_AXI_DATA_WIDTH reset image for the RW registers.

Ports:
- Bus2IP_Clk  in  1  sole clock.
- Bus2IP_Resetn  in  1  asynchronous active-low reset.
- Bus2IP_Addr  in  C_S_AXI_ADDR_WIDTH  byte address.
- Bus2IP_CS  in  1  chip select; held high until acked.
- Bus2IP_RNW  in  1  1 = read, 0 = write.
- Bus2IP_Data  in  C_S_AXI_DATA_WIDTH  write data.
- Bus2IP_BE  in  C_S_AXI_DATA_WIDTH/8  write byte enables.
- IP2Bus_Data  out  C_S_AXI_DATA_WIDTH  read data.
- IP2Bus_RdAck  out  1  read acknowledge.
- IP2Bus_WrAck  out  1  write acknowledge.
- IP2Bus_Error  out  1  unmapped access; valid with the ack.
- wo_regs  out  NUM_WO_REGS*C_S_AXI_DATA_WIDTH  packed WO registers, reg 0 in the LSBs.
- rw_regs  out  NUM_RW_REGS*C_S_AXI_DATA_WIDTH  packed RW registers.
- ro_regs  in  NUM_RO_REGS*C_S_AXI_DATA_WIDTH  packed RO values.
- wr_strobe  out  NUM_WO_REGS+NUM_RW_REGS  one-cycle pulse per written WO/RW register (WO first).
- rd_strobe  out  NUM_RO_REGS  one-cycle pulse per read RO register.
- w1c_set  in  NUM_W1C_REGS*C_S_AXI_DATA_WIDTH  per-bit hardware set pulses.
- w1c_regs  out  NUM_W1C_REGS*C_S_AXI_DATA_WIDTH  current status.
- irq  out  1  level interrupt.

Behaviour:
- Clock/reset: one clock, Bus2IP_Clk. Reset Bus2IP_Resetn is asynchronous, active-low; every flop clears on assertion with no clock needed.
- Reset values: outputs, strobes, acks, Error, irq, W1C and mask registers all 0. WO registers 0. RW registers = RW_RESET_VALUE.
- Address decode:
  - ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8).
  - TOTAL = WO+RW+RO+2*W1C.
  - IDX_W = max(1, ceil(log2(TOTAL))).
  - idx = Bus2IP_Addr[ADDR_LSB +: IDX_W]; higher address bits are ignored.
- Map order by idx: WO, RW, RO, W1C, MASK. Defaults: 0x00 WO0, 0x04 RW0, 0x08 RW1, 0x0C RO0, 0x10 W1C0, 0x14 MASK0; 0x18 and 0x1C are unmapped.
- FSM:
  - IDLE: CS=1 → ACK. The access is executed on this edge.
  - ACK: exactly one cycle of RdAck or WrAck per RNW → WAIT.
  - WAIT: stay while CS=1; CS=0 → IDLE.
  - Latency: ack in the cycle after CS is first sampled high. Exactly one ack and one side effect per CS assertion.
- Write, per region:
  - WO/RW/MASK: per-byte update where BE=1; wr_strobe bit pulses concurrently with WrAck.
  - RO: ignored, acked, Error=0.
  - W1C: bits with data=1 and BE=1 clear.
- W1C update every cycle: next = (cur & ~clr) | set. Set wins over a same-cycle clear.
- Read, per region:
  - WO: returns 0, Error=0.
  - RW/W1C/MASK: return current value.
  - RO: returns the ro_regs value sampled at the access edge; rd_strobe pulses with RdAck.
- Unmapped idx (>= TOTAL): ack with Error=1, data 0, no side effect.
- IP2Bus_Data: holds the last read value; updated only on read accesses.
- irq: registered OR over all (w1c & mask), one cycle after the status/mask change.
- Reset mid-access: FSM returns to IDLE immediately; a pending ack is lost.

Optional Feature:
- Macro IPIF_REG_BANK_RD_PIPE_EN.
- Defined: an extra register stage on the read mux. The FSM inserts a RDWAIT state between IDLE and ACK for reads only, so the read ack comes 2 cycles after CS; RO sampling and rd_strobe move to the RDWAIT edge. Writes unchanged.
- Undefined: read ack 1 cycle after CS, as above.

Test Plan:
- Reset release → all outputs 0; rw_regs = RW_RESET_VALUE; read 0x04 with RW_RESET_VALUE[31:0]=0x0000_00A5 → data 0x0000_00A5, one RdAck.
- Write 0x08 data 0xDEADBEEF BE=0b0101 over 0 → rw_regs[63:32]=0x00AD00EF, wr_strobe[2] pulses once, one WrAck despite CS held 4 cycles.
- Pulse w1c_set bit3, write 0x14 data 0x8 → irq=1 next cycle. Write 0x10 data 0x8 in the same cycle as a set on bit3 → bit stays 1. Write again without the set → bit clears, irq falls.
- Read 0x18 and write 0x1C → ack with Error=1, data 0, no register changes.
- ro_regs=0x1234_5678, read 0x0C → data 0x12345678, rd_strobe pulses. Write 0x0C → WrAck, Error=0, no effect.
- Assert Bus2IP_Resetn low during ACK → acks drop asynchronously, FSM in IDLE, next access completes normally. Repeat with IPIF_REG_BANK_RD_PIPE_EN defined: read ack at CS+2.

Source files
------------

// File: rtl/ipif_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : ipif_reg_bank_if
// Description : IPIF bus bundle between the AXI-Lite IPIF shim (master) and
//               the register bank (slave): address, chip select, direction,
//               write data/byte enables, read data, acks and error.
// Revision    : 1.0 - initial release
// ============================================================================
interface ipif_reg_bank_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr;
    logic                            Bus2IP_CS;
    logic                            Bus2IP_RNW;
    logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE;
    logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data;
    logic                            IP2Bus_RdAck;
    logic                            IP2Bus_WrAck;
    logic                            IP2Bus_Error;

    modport master (
        output Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );

    modport slave (
        input  Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );
endinterface
`default_nettype wire

// File: rtl/ipif_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : ipif_reg_bank
// Description : Parametrised IPIF slave register bank. Map order by word
//               index: WO, RW, RO, W1C status, W1C mask. Byte enables honoured,
//               per-register access strobes, registered irq, single-ack FSM
//               with error ack for unmapped indices.
//               Optional macro IPIF_REG_BANK_RD_PIPE_EN: registers the read
//               index and inserts an RDWAIT state, read ack at CS+2.
// Revision    : 1.0 - initial release
// ============================================================================
module ipif_reg_bank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_WO_REGS        = 1,
    parameter int NUM_RW_REGS        = 2,
    parameter int NUM_RO_REGS        = 1,
    parameter int NUM_W1C_REGS       = 1,
    parameter logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] RW_RESET_VALUE = '0
) (
    input  wire logic                                       Bus2IP_Clk,
    input  wire logic                                       Bus2IP_Resetn,
    ipif_reg_bank_if.slave                                  bus,
    output logic [NUM_WO_REGS*C_S_AXI_DATA_WIDTH-1:0]       wo_regs,
    output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]       rw_regs,
    input  wire logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0]  ro_regs,
    output logic [NUM_WO_REGS+NUM_RW_REGS-1:0]              wr_strobe,
    output logic [NUM_RO_REGS-1:0]                          rd_strobe,
    input  wire logic [NUM_W1C_REGS*C_S_AXI_DATA_WIDTH-1:0] w1c_set,
    output logic [NUM_W1C_REGS*C_S_AXI_DATA_WIDTH-1:0]      w1c_regs,
    output logic                                            irq
);
    localparam int c_DW        = C_S_AXI_DATA_WIDTH;
    localparam int c_BE_W      = c_DW / 8;
    localparam int c_ADDR_LSB  = $clog2(c_BE_W);
    localparam int c_TOTAL     = NUM_WO_REGS + NUM_RW_REGS + NUM_RO_REGS + 2*NUM_W1C_REGS;
    localparam int c_IDX_W     = (c_TOTAL <= 2) ? 1 : $clog2(c_TOTAL);
    localparam int c_RW_BASE   = NUM_WO_REGS;
    localparam int c_RO_BASE   = c_RW_BASE + NUM_RW_REGS;
    localparam int c_W1C_BASE  = c_RO_BASE + NUM_RO_REGS;
    localparam int c_MASK_BASE = c_W1C_BASE + NUM_W1C_REGS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACK    = 2'd1,
        S_WAIT   = 2'd2,
        S_RDWAIT = 2'd3
    } state_t;

    state_t                                 r_state;
    logic [c_DW-1:0]                        r_wo   [NUM_WO_REGS];
    logic [c_DW-1:0]                        r_rw   [NUM_RW_REGS];
    logic [c_DW-1:0]                        r_w1c  [NUM_W1C_REGS];
    logic [c_DW-1:0]                        r_mask [NUM_W1C_REGS];
    logic [c_DW-1:0]                        r_rdata;
    logic                                   r_rdack;
    logic                                   r_wrack;
    logic                                   r_err;
    logic                                   r_irq;
    logic [NUM_WO_REGS+NUM_RW_REGS-1:0]     r_wr_strobe;
    logic [NUM_RO_REGS-1:0]                 r_rd_strobe;

    logic [c_IDX_W-1:0]                     w_idx;
    logic [31:0]                            w_idx32;
    logic [31:0]                            w_rd_idx32;
    logic [c_DW-1:0]                        w_be_mask;
    logic                                   w_wr_go;
    logic [c_DW-1:0]                        w_w1c_clr [NUM_W1C_REGS];
    logic [c_DW-1:0]                        w_rd_data;
    logic                                   w_rd_err;
    logic [NUM_RO_REGS-1:0]                 w_rd_ro_hit;
    logic                                   w_pending;
    logic                                   w_unused;

    assign w_idx    = bus.Bus2IP_Addr[c_ADDR_LSB +: c_IDX_W];
    assign w_idx32  = 32'(w_idx);
    assign w_wr_go  = (r_state == S_IDLE) && bus.Bus2IP_CS && !bus.Bus2IP_RNW;
    // Address bits above the index are don't-care
    assign w_unused = ^bus.Bus2IP_Addr;

`ifdef IPIF_REG_BANK_RD_PIPE_EN
    logic [31:0] r_idx32;
    // Read index captured at CS so the read mux is fed from a register
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn)                                 r_idx32 <= '0;
        else if (r_state == S_IDLE && bus.Bus2IP_CS)        r_idx32 <= w_idx32;
    end
    assign w_rd_idx32 = r_idx32;
`else
    assign w_rd_idx32 = w_idx32;
`endif

    // Expand byte enables into a bit mask
    always_comb begin
        w_be_mask = '0;
        for (int b = 0; b < c_BE_W; b++) begin
            w_be_mask[b*8 +: 8] = {8{bus.Bus2IP_BE[b]}};
        end
    end

    // Read mux: region decode of the read index, unmapped flags an error
    always_comb begin
        w_rd_data   = '0;
        w_rd_err    = (w_rd_idx32 >= c_TOTAL);
        w_rd_ro_hit = '0;
        for (int k = 0; k < NUM_RW_REGS; k++)
            if (w_rd_idx32 == c_RW_BASE + k)   w_rd_data = r_rw[k];
        for (int k = 0; k < NUM_RO_REGS; k++)
            if (w_rd_idx32 == c_RO_BASE + k) begin
                w_rd_data      = ro_regs[k*c_DW +: c_DW];
                w_rd_ro_hit[k] = 1'b1;
            end
        for (int k = 0; k < NUM_W1C_REGS; k++) begin
            if (w_rd_idx32 == c_W1C_BASE + k)  w_rd_data = r_w1c[k];
            if (w_rd_idx32 == c_MASK_BASE + k) w_rd_data = r_mask[k];
        end
    end

    // Software clear vector for the W1C registers (data=1 and BE=1)
    always_comb begin
        for (int k = 0; k < NUM_W1C_REGS; k++) begin
            w_w1c_clr[k] = '0;
            if (w_wr_go && (w_idx32 == c_W1C_BASE + k))
                w_w1c_clr[k] = bus.Bus2IP_Data & w_be_mask;
        end
    end

    // Pending interrupt: any status bit enabled by its mask
    always_comb begin
        w_pending = 1'b0;
        for (int k = 0; k < NUM_W1C_REGS; k++)
            w_pending = w_pending | (|(r_w1c[k] & r_mask[k]));
    end

    // Access FSM: executes the access, registers acks, strobes and read data
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_state     <= S_IDLE;
            r_rdata     <= '0;
            r_rdack     <= 1'b0;
            r_wrack     <= 1'b0;
            r_err       <= 1'b0;
            r_wr_strobe <= '0;
            r_rd_strobe <= '0;
            for (int k = 0; k < NUM_WO_REGS; k++)  r_wo[k]   <= '0;
            for (int k = 0; k < NUM_RW_REGS; k++)  r_rw[k]   <= RW_RESET_VALUE[k*c_DW +: c_DW];
            for (int k = 0; k < NUM_W1C_REGS; k++) r_mask[k] <= '0;
        end else begin
            r_rdack     <= 1'b0;
            r_wrack     <= 1'b0;
            r_err       <= 1'b0;
            r_wr_strobe <= '0;
            r_rd_strobe <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Bus2IP_CS) begin
                        if (bus.Bus2IP_RNW) begin
`ifdef IPIF_REG_BANK_RD_PIPE_EN
                            r_state <= S_RDWAIT;
`else
                            r_rdack     <= 1'b1;
                            r_err       <= w_rd_err;
                            r_rdata     <= w_rd_data;
                            r_rd_strobe <= w_rd_ro_hit;
                            r_state     <= S_ACK;
`endif
                        end else begin
                            r_wrack <= 1'b1;
                            r_err   <= (w_idx32 >= c_TOTAL);
                            r_state <= S_ACK;
                            for (int k = 0; k < NUM_WO_REGS; k++)
                                if (w_idx32 == k) begin
                                    r_wo[k] <= (r_wo[k] & ~w_be_mask) | (bus.Bus2IP_Data & w_be_mask);
                                    r_wr_strobe[k] <= 1'b1;
                                end
                            for (int k = 0; k < NUM_RW_REGS; k++)
                                if (w_idx32 == c_RW_BASE + k) begin
                                    r_rw[k] <= (r_rw[k] & ~w_be_mask) | (bus.Bus2IP_Data & w_be_mask);
                                    r_wr_strobe[c_RW_BASE + k] <= 1'b1;
                                end
                            for (int k = 0; k < NUM_W1C_REGS; k++)
                                if (w_idx32 == c_MASK_BASE + k)
                                    r_mask[k] <= (r_mask[k] & ~w_be_mask) | (bus.Bus2IP_Data & w_be_mask);
                        end
                    end
                end
                S_RDWAIT: begin
                    r_rdack     <= 1'b1;
                    r_err       <= w_rd_err;
                    r_rdata     <= w_rd_data;
                    r_rd_strobe <= w_rd_ro_hit;
                    r_state     <= S_ACK;
                end
                S_ACK: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.Bus2IP_CS) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky status: hardware set wins over a same-cycle software clear
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            for (int k = 0; k < NUM_W1C_REGS; k++) r_w1c[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_W1C_REGS; k++)
                r_w1c[k] <= (r_w1c[k] & ~w_w1c_clr[k]) | w1c_set[k*c_DW +: c_DW];
        end
    end

    // Registered interrupt level
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) r_irq <= 1'b0;
        else                r_irq <= w_pending;
    end

    for (genvar g = 0; g < NUM_WO_REGS; g++) begin : g_wo_out
        assign wo_regs[g*c_DW +: c_DW] = r_wo[g];
    end
    for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_rw_out
        assign rw_regs[g*c_DW +: c_DW] = r_rw[g];
    end
    for (genvar g = 0; g < NUM_W1C_REGS; g++) begin : g_w1c_out
        assign w1c_regs[g*c_DW +: c_DW] = r_w1c[g];
    end

    assign bus.IP2Bus_Data  = r_rdata;
    assign bus.IP2Bus_RdAck = r_rdack;
    assign bus.IP2Bus_WrAck = r_wrack;
    assign bus.IP2Bus_Error = r_err;
    assign wr_strobe        = r_wr_strobe;
    assign rd_strobe        = r_rd_strobe;
    assign irq              = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_ipif_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipif_reg_bank
// Description : Directed self-checking bench for ipif_reg_bank (default map:
//               WO0 0x00, RW0 0x04, RW1 0x08, RO0 0x0C, W1C0 0x10, MASK0 0x14).
//               Honours IPIF_REG_BANK_RD_PIPE_EN for the expected read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipif_reg_bank;
    localparam logic [63:0] c_RWRST = 64'h0000_0000_0000_00A5;
`ifdef IPIF_REG_BANK_RD_PIPE_EN
    localparam int c_RD_LAT = 2;
`else
    localparam int c_RD_LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] wo_regs;
    logic [63:0] rw_regs;
    logic [31:0] ro_regs;
    logic [2:0]  wr_strobe;
    logic [0:0]  rd_strobe;
    logic [31:0] w1c_set;
    logic [31:0] w1c_regs;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    ipif_reg_bank_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) bus_if ();

    ipif_reg_bank #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .NUM_WO_REGS        (1),
        .NUM_RW_REGS        (2),
        .NUM_RO_REGS        (1),
        .NUM_W1C_REGS       (1),
        .RW_RESET_VALUE     (c_RWRST)
    ) dut (
        .Bus2IP_Clk    (clk),
        .Bus2IP_Resetn (rst_n),
        .bus           (bus_if),
        .wo_regs       (wo_regs),
        .rw_regs       (rw_regs),
        .ro_regs       (ro_regs),
        .wr_strobe     (wr_strobe),
        .rd_strobe     (rd_strobe),
        .w1c_set       (w1c_set),
        .w1c_regs      (w1c_regs),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus access: CS held for 'hold' cycles then two idle cycles.
    // Records ack count/latency and strobe activity; 'set' drives w1c_set
    // alongside the first CS edge only.
    task automatic bus_access(input logic [31:0] addr, input logic rnw,
                              input logic [31:0] data, input logic [3:0] be,
                              input logic [31:0] set, input int hold,
                              output logic [31:0] rdata, output logic err,
                              output int nacks, output int lat,
                              output logic [2:0] wrs, output logic [0:0] rds,
                              output int nstb);
        rdata = 'x; err = 1'bx; nacks = 0; lat = 0; wrs = '0; rds = '0; nstb = 0;
        bus_if.Bus2IP_Addr = addr;
        bus_if.Bus2IP_RNW  = rnw;
        bus_if.Bus2IP_Data = data;
        bus_if.Bus2IP_BE   = be;
        bus_if.Bus2IP_CS   = 1'b1;
        w1c_set            = set;
        for (int c = 1; c <= hold + 2; c++) begin
            @(posedge clk); #1;
            if (c == 1)    w1c_set = '0;
            if (c == hold) bus_if.Bus2IP_CS = 1'b0;
            if (wr_strobe != 0 || rd_strobe != 0) nstb++;
            if (bus_if.IP2Bus_RdAck || bus_if.IP2Bus_WrAck) begin
                nacks++;
                if (lat == 0) lat = c;
                rdata = bus_if.IP2Bus_Data;
                err   = bus_if.IP2Bus_Error;
                wrs   = wr_strobe;
                rds   = rd_strobe;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e; int n, l, s; logic [2:0] ws; logic [0:0] rs;
        rst_n = 1'b0;
        bus_if.Bus2IP_CS = 1'b0; bus_if.Bus2IP_RNW = 1'b1; bus_if.Bus2IP_Addr = '0;
        bus_if.Bus2IP_Data = '0; bus_if.Bus2IP_BE = '0;
        ro_regs = '0; w1c_set = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({bus_if.IP2Bus_Data, bus_if.IP2Bus_RdAck, bus_if.IP2Bus_WrAck, bus_if.IP2Bus_Error} !== 35'd0)
            $display("FAIL reset_bus: got %h/%b%b%b want 0/000", bus_if.IP2Bus_Data,
                     bus_if.IP2Bus_RdAck, bus_if.IP2Bus_WrAck, bus_if.IP2Bus_Error);
        else n_pass++;
        n_total++;
        if ({wo_regs, w1c_regs, wr_strobe, rd_strobe, irq} !== 69'd0)
            $display("FAIL reset_outs: wo=%h w1c=%h wrs=%b rds=%b irq=%b want all 0",
                     wo_regs, w1c_regs, wr_strobe, rd_strobe, irq);
        else n_pass++;
        n_total++;
        if (rw_regs !== c_RWRST) $display("FAIL reset_rw: got %h want %h", rw_regs, c_RWRST);
        else n_pass++;
        bus_access(32'h04, 1'b1, '0, 4'h0, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (d !== 32'h0000_00A5 || e !== 1'b0 || n != 1 || l != c_RD_LAT)
            $display("FAIL read_rw0_reset: data=%h err=%b acks=%0d lat=%0d want 000000a5 0 1 %0d",
                     d, e, n, l, c_RD_LAT);
        else n_pass++;
    endtask

    task automatic test_byte_enable();
        logic [31:0] d; logic e; int n, l, s; logic [2:0] ws; logic [0:0] rs;
        bus_access(32'h08, 1'b0, 32'hDEAD_BEEF, 4'b0101, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (rw_regs !== {32'h00AD_00EF, 32'h0000_00A5})
            $display("FAIL be_rw1: got %h want 00ad00ef000000a5", rw_regs);
        else n_pass++;
        n_total++;
        if (n != 1 || l != 1 || e !== 1'b0 || ws !== 3'b100 || s != 1)
            $display("FAIL be_ack_strobe: acks=%0d lat=%0d err=%b wrs=%b stbcyc=%0d want 1 1 0 100 1",
                     n, l, e, ws, s);
        else n_pass++;
        bus_access(32'h00, 1'b0, 32'h1122_3344, 4'hF, '0, 3, d, e, n, l, ws, rs, s);
        n_total++;
        if (wo_regs !== 32'h1122_3344 || ws !== 3'b001 || n != 1)
            $display("FAIL wo_write: wo=%h wrs=%b acks=%0d want 11223344 001 1", wo_regs, ws, n);
        else n_pass++;
        bus_access(32'h00, 1'b1, '0, 4'h0, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (d !== 32'h0 || e !== 1'b0 || n != 1)
            $display("FAIL wo_read: data=%h err=%b acks=%0d want 0 0 1", d, e, n);
        else n_pass++;
    endtask

    task automatic test_w1c();
        logic [31:0] d; logic e; int n, l, s; logic [2:0] ws; logic [0:0] rs;
        w1c_set = 32'h8;
        @(posedge clk); #1 w1c_set = '0;
        n_total++;
        if (w1c_regs !== 32'h8 || irq !== 1'b0)
            $display("FAIL w1c_set: w1c=%h irq=%b want 00000008 0", w1c_regs, irq);
        else n_pass++;
        bus_access(32'h14, 1'b0, 32'h8, 4'hF, '0, 3, d, e, n, l, ws, rs, s);
        n_total++;
        if (irq !== 1'b1 || ws !== 3'b000) $display("FAIL mask_irq: irq=%b wrs=%b want 1 000", irq, ws);
        else n_pass++;
        bus_access(32'h10, 1'b1, '0, 4'h0, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (d !== 32'h8 || n != 1) $display("FAIL w1c_read: data=%h acks=%0d want 00000008 1", d, n);
        else n_pass++;
        bus_access(32'h10, 1'b0, 32'h8, 4'hF, 32'h8, 3, d, e, n, l, ws, rs, s);
        n_total++;
        if (w1c_regs !== 32'h8 || irq !== 1'b1)
            $display("FAIL w1c_set_wins: w1c=%h irq=%b want 00000008 1", w1c_regs, irq);
        else n_pass++;
        bus_access(32'h10, 1'b0, 32'h8, 4'hF, '0, 3, d, e, n, l, ws, rs, s);
        n_total++;
        if (w1c_regs !== 32'h0 || irq !== 1'b0)
            $display("FAIL w1c_clear: w1c=%h irq=%b want 0 0", w1c_regs, irq);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic e; int n, l, s; logic [2:0] ws; logic [0:0] rs;
        logic [31:0] wo0, w10; logic [63:0] rw0;
        bus_access(32'h0100_0004, 1'b1, '0, 4'h0, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (d !== 32'h0000_00A5 || e !== 1'b0)
            $display("FAIL high_addr_ignored: data=%h err=%b want 000000a5 0", d, e);
        else n_pass++;
        wo0 = wo_regs; rw0 = rw_regs; w10 = w1c_regs;
        bus_access(32'h18, 1'b1, '0, 4'h0, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (d !== 32'h0 || e !== 1'b1 || n != 1 || s != 0)
            $display("FAIL unmapped_read: data=%h err=%b acks=%0d stb=%0d want 0 1 1 0", d, e, n, s);
        else n_pass++;
        bus_access(32'h1C, 1'b0, 32'hFFFF_FFFF, 4'hF, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (e !== 1'b1 || n != 1 || s != 0 || bus_if.IP2Bus_Data !== 32'h0)
            $display("FAIL unmapped_write: err=%b acks=%0d stb=%0d data=%h want 1 1 0 0",
                     e, n, s, bus_if.IP2Bus_Data);
        else n_pass++;
        n_total++;
        if (wo_regs !== wo0 || rw_regs !== rw0 || w1c_regs !== w10 || irq !== 1'b0)
            $display("FAIL unmapped_no_effect: wo=%h rw=%h w1c=%h irq=%b want %h %h %h 0",
                     wo_regs, rw_regs, w1c_regs, irq, wo0, rw0, w10);
        else n_pass++;
    endtask

    task automatic test_ro();
        logic [31:0] d; logic e; int n, l, s; logic [2:0] ws; logic [0:0] rs;
        logic [31:0] wo0; logic [63:0] rw0;
        ro_regs = 32'h1234_5678;
        bus_access(32'h0C, 1'b1, '0, 4'h0, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (d !== 32'h1234_5678 || e !== 1'b0 || rs !== 1'b1 || s != 1 || l != c_RD_LAT)
            $display("FAIL ro_read: data=%h err=%b rds=%b stb=%0d lat=%0d want 12345678 0 1 1 %0d",
                     d, e, rs, s, l, c_RD_LAT);
        else n_pass++;
        wo0 = wo_regs; rw0 = rw_regs;
        bus_access(32'h0C, 1'b0, 32'hCAFE_F00D, 4'hF, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (e !== 1'b0 || n != 1 || s != 0 || wo_regs !== wo0 || rw_regs !== rw0)
            $display("FAIL ro_write: err=%b acks=%0d stb=%0d wo=%h rw=%h want 0 1 0 unchanged",
                     e, n, s, wo_regs, rw_regs);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] d; logic e; int n, l, s; logic [2:0] ws; logic [0:0] rs;
        bit seen;
        bus_access(32'h04, 1'b0, 32'h0000_0055, 4'hF, '0, 3, d, e, n, l, ws, rs, s);
        bus_if.Bus2IP_Addr = 32'h04; bus_if.Bus2IP_RNW = 1'b1; bus_if.Bus2IP_CS = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus_if.IP2Bus_RdAck) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL mid_ack_seen: no RdAck within 4 cycles");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus_if.IP2Bus_RdAck !== 1'b0 || bus_if.IP2Bus_WrAck !== 1'b0 ||
            rw_regs !== c_RWRST || wo_regs !== 32'h0)
            $display("FAIL async_reset: rdack=%b wrack=%b rw=%h wo=%h want 0 0 %h 0",
                     bus_if.IP2Bus_RdAck, bus_if.IP2Bus_WrAck, rw_regs, wo_regs, c_RWRST);
        else n_pass++;
        bus_if.Bus2IP_CS = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus_access(32'h04, 1'b1, '0, 4'h0, '0, 4, d, e, n, l, ws, rs, s);
        n_total++;
        if (d !== 32'h0000_00A5 || n != 1 || l != c_RD_LAT || e !== 1'b0)
            $display("FAIL after_reset_read: data=%h acks=%0d lat=%0d err=%b want 000000a5 1 %0d 0",
                     d, n, l, e, c_RD_LAT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_w1c();
        test_unmapped();
        test_ro();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire
